// File: rtl/counter_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl_pkg
// Description : Shared definitions for the counter sequencer: FSM state
//               encoding, count-direction encoding, the latched run
//               configuration record and a small state-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_ctrl_pkg;

    // Sequencer states (2-bit encoding)
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_PAUSED = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // Count direction
    localparam logic c_DIR_UP   = 1'b0;
    localparam logic c_DIR_DOWN = 1'b1;

    // Run configuration captured on an accepted start
    typedef struct packed {
        logic dir;
        logic auto_reload;
    } run_cfg_t;

    // A run is in progress (counting or paused)
    function automatic logic is_busy(input logic [1:0] st);
        return (st == c_RUN) || (st == c_PAUSED);
    endfunction

endpackage : counter_seq_ctrl_pkg
`default_nettype wire

// File: rtl/counter_seq_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : counter_core
// Description : WIDTH-bit synchronous counter register. Load has priority
//               over enable; enable steps by one in the direction given by
//               i_dir, wrapping modulo 2^WIDTH. No control logic.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load, i_load_val - parallel load
//               i_en, i_dir     - step enable and direction
//               o_count         - registered counter value
// Revision    : 1.0 - initial release
// ============================================================================
module counter_core
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            if (i_dir == c_DIR_DOWN) begin
                r_count <= r_count - WIDTH'(1);
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule : counter_core
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Run sequencer for the binary counter. Loads a start value,
//               steps up/down once per cycle until the latched terminal
//               value, then stops (one-shot) or reloads (auto-reload).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start, stop      - run request / abort
//               pause            - level hold of the count
//               dir, auto_reload, load_val, term_val - run configuration
//               count            - registered counter value
//               busy             - run in progress (RUN or PAUSED)
//               done             - one-cycle pulse per terminal hit
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    logic [1:0]       r_state;
    run_cfg_t         r_cfg;
    logic [WIDTH-1:0] r_term;
    logic             r_done;

    logic             w_start_ok;
    logic             w_advance;
    logic             w_hit;
    logic             w_load;
    logic             w_en;

    // The cycle after a pause is released behaves like a normal RUN cycle
    // (step or terminal check), so each paused cycle costs exactly one cycle.
    always_comb begin
        w_start_ok = start && ((r_state == c_IDLE) || (r_state == c_DONE));
        w_advance  = is_busy(r_state) && !pause;
        w_hit      = (count == r_term);
        // Reload uses the live load_val, both on start and on auto-reload.
        w_load     = !stop && (w_start_ok || (w_advance && w_hit && r_cfg.auto_reload));
        w_en       = !stop && w_advance && !w_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cfg   <= '0;
            r_term  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= c_IDLE;
            end else if (w_start_ok) begin
                r_cfg.dir         <= dir;
                r_cfg.auto_reload <= auto_reload;
                r_term            <= term_val;
                r_state           <= c_RUN;
            end else if (is_busy(r_state)) begin
                if (pause) begin
                    r_state <= c_PAUSED;
                end else if (w_hit) begin
                    r_done  <= 1'b1;
                    r_state <= r_cfg.auto_reload ? c_RUN : c_DONE;
                end else begin
                    r_state <= c_RUN;
                end
            end
        end
    end

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (load_val),
        .i_en       (w_en),
        .i_dir      (r_cfg.dir),
        .o_count    (count)
    );

    assign busy = is_busy(r_state);
    assign done = r_done;

endmodule : counter_seq_ctrl
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Self-checking bench for counter_seq_ctrl. A table of
//               per-cycle input records with hand-computed expected outputs,
//               plus hand-written auto-reload period and stop-on-terminal
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic       dir;
        logic       ar;
        logic [2:0] ld;
        logic [2:0] tm;
        logic [2:0] ec;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs[$];

    counter_seq_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .dir         (dir),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .term_val    (term_val),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // rst, start, stop, pause, dir, auto_reload, load, term -> count, busy, done
    task automatic add(input logic r, input logic s, input logic sp,
                       input logic p, input logic d, input logic a,
                       input int ld, input int tm,
                       input int ec, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = sp; v.pause = p; v.dir = d; v.ar = a;
        v.ld = 3'(ld); v.tm = 3'(tm); v.ec = 3'(ec); v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; stop = 0; pause = 0;
        dir = 0; auto_reload = 0; load_val = '0; term_val = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;

        // Reset, one-shot up-count 2..5 (mid-run config changes ignored)
        add(1,0,0,0,0,0, 0,0, 0,0,0);
        add(0,1,0,0,0,0, 2,5, 2,1,0);
        add(0,0,0,0,1,1, 0,3, 3,1,0);
        add(0,0,0,0,1,1, 0,3, 4,1,0);
        add(0,0,0,0,0,0, 0,0, 5,1,0);
        add(0,0,0,0,0,0, 0,0, 5,0,1);
        add(0,0,0,0,0,0, 0,0, 5,0,0);
        add(0,0,0,0,0,0, 0,0, 5,0,0);
        // Up wrap 6,7,0,1
        add(0,1,0,0,0,0, 6,1, 6,1,0);
        add(0,0,0,0,0,0, 0,0, 7,1,0);
        add(0,0,0,0,0,0, 0,0, 0,1,0);
        add(0,0,0,0,0,0, 0,0, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 1,0,1);
        // Down wrap 1,0,7,6
        add(0,1,0,0,1,0, 1,6, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 0,1,0);
        add(0,0,0,0,0,0, 0,0, 7,1,0);
        add(0,0,0,0,0,0, 0,0, 6,1,0);
        add(0,0,0,0,0,0, 0,0, 6,0,1);
        // Pause 3 cycles at count=3: done moves from E4 to E7
        add(0,1,0,0,0,0, 2,5, 2,1,0);
        add(0,0,0,0,0,0, 0,0, 3,1,0);
        add(0,1,0,1,0,0, 0,0, 3,1,0);
        add(0,0,0,1,0,0, 0,0, 3,1,0);
        add(0,0,0,1,0,0, 0,0, 3,1,0);
        add(0,0,0,0,0,0, 0,0, 4,1,0);
        add(0,0,0,0,0,0, 0,0, 5,1,0);
        add(0,0,0,0,0,0, 0,0, 5,0,1);
        add(0,0,0,0,0,0, 0,0, 5,0,0);
        // Auto-reload 0..2, start pulses ignored mid-run, then stop
        add(0,1,0,0,0,1, 0,2, 0,1,0);
        add(0,0,0,0,0,0, 0,0, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 2,1,0);
        add(0,0,0,0,0,0, 0,0, 0,1,1);
        add(0,1,0,0,1,0, 0,7, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 2,1,0);
        add(0,1,0,0,0,0, 0,0, 0,1,1);
        add(0,0,0,0,0,0, 0,0, 1,1,0);
        add(0,0,1,0,0,0, 0,0, 1,0,0);
        // Stop at count=4
        add(0,1,0,0,0,0, 2,5, 2,1,0);
        add(0,0,0,0,0,0, 0,0, 3,1,0);
        add(0,0,0,0,0,0, 0,0, 4,1,0);
        add(0,0,1,0,0,0, 0,0, 4,0,0);
        add(0,0,0,0,0,0, 0,0, 4,0,0);
        // Reset during run
        add(0,1,0,0,0,0, 1,6, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 2,1,0);
        add(1,0,0,0,0,0, 0,0, 0,0,0);
        add(0,0,0,0,0,0, 0,0, 0,0,0);
        // load==term, then relaunch from DONE with wrap to 0
        add(0,1,0,0,0,0, 3,3, 3,1,0);
        add(0,0,0,0,0,0, 0,0, 3,0,1);
        add(0,0,0,0,0,0, 0,0, 3,0,0);
        add(0,1,0,0,0,0, 6,0, 6,1,0);
        add(0,0,0,0,0,0, 0,0, 7,1,0);
        add(0,0,0,0,0,0, 0,0, 0,1,0);
        add(0,0,0,0,0,0, 0,0, 0,0,1);
        // Pause on the terminal cycle: no done until released
        add(0,1,0,0,0,0, 1,2, 1,1,0);
        add(0,0,0,0,0,0, 0,0, 2,1,0);
        add(0,0,0,1,0,0, 0,0, 2,1,0);
        add(0,0,0,0,0,0, 0,0, 2,0,1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            pause = vecs[i].pause; dir = vecs[i].dir; auto_reload = vecs[i].ar;
            load_val = vecs[i].ld; term_val = vecs[i].tm;
            @(posedge clk);
            @(negedge clk);
            check("vec_count", i, 8'(count), 8'(vecs[i].ec));
            check("vec_busy",  i, 8'(busy),  8'(vecs[i].eb));
            check("vec_done",  i, 8'(done),  8'(vecs[i].ed));
        end

        // Auto-reload down-count 5..1: d=4, done every 5 cycles, busy held
        idle_inputs();
        start = 1; load_val = 3'd5; term_val = 3'd1; dir = 1; auto_reload = 1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        load_val = 3'd5;
        check("ar_load", 0, 8'(count), 8'd5);
        for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("ar_count", i, 8'(count), 8'(5 - (i % 5)));
            check("ar_done",  i, 8'(done),  8'((i % 5) == 0));
            check("ar_busy",  i, 8'(busy),  8'd1);
        end
        stop = 1;
        @(posedge clk);
        @(negedge clk);
        stop = 0;
        check("ar_stop_busy", 0, 8'(busy), 8'd0);

        // Stop on the edge that would have been the terminal hit
        start = 1; load_val = 3'd0; term_val = 3'd2;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("st_pre_count", 0, 8'(count), 8'd2);
        stop = 1;
        @(posedge clk);
        @(negedge clk);
        stop = 0;
        check("st_count", 0, 8'(count), 8'd2);
        check("st_busy",  0, 8'(busy),  8'd0);
        check("st_done",  0, 8'(done),  8'd0);
        @(posedge clk);
        @(negedge clk);
        check("st_done_after", 0, 8'(done), 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_counter_seq_ctrl
`default_nettype wire

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Synchronous sequencer for the team's binary counter datapath. It replaces free-running ripple operation with a controlled count run: load a start value, step up or down once per cycle until a terminal value, then stop or auto-reload. It sits between a host or control FSM and the counter register, and exposes a start/busy/done handshake plus pause and abort controls.

## Interface
- WIDTH, 3, counter width in bits
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; accepted only in IDLE or DONE
- stop  in  1  abort; forces IDLE from any state
- pause  in  1  level; holds the count while high
- dir  in  1  0 = count up, 1 = count down; sampled on accepted start
- auto_reload  in  1  1 = reload on terminal and keep running; sampled on accepted start
- load_val  in  WIDTH  start value; sampled on accepted start
- term_val  in  WIDTH  terminal value; sampled on accepted start
- count  out  WIDTH  current counter value (registered)
- busy  out  1  high in RUN and PAUSED
- done  out  1  one-cycle registered pulse per terminal hit

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Priority per edge: rst > stop > start > pause > step.
- Reset: state=IDLE, count=0, busy=0, done=0, latched dir/auto_reload/term_val=0.
- IDLE/DONE with start=1: count<=load_val, latch dir, auto_reload and term_val, state<=RUN.
- RUN with pause=1: state<=PAUSED, count holds, no terminal check.
- PAUSED with pause=0: state<=RUN. A start received in PAUSED is ignored.
- RUN with pause=0 and count==term_val (latched): done<=1. If auto_reload, count<=load_val (live input at that edge) and stay in RUN. Otherwise state<=DONE and count holds.
- RUN with pause=0 and count!=term_val: count<=count+1 (dir=0) or count-1 (dir=1), modulo 2^WIDTH. Wrap 7->0 and 0->7 is normal stepping, not a terminal event.
- DONE: count holds, busy=0. Leaves only on start or stop.
- stop: state<=IDLE, count holds its value, done<=0.
- start in RUN/PAUSED is ignored. Changes to dir, term_val and auto_reload mid-run have no effect.
- done is 0 on every edge that is not a terminal hit.

## Timing
- Accepted start at edge E0: count=load_val and busy=1 visible after E0.
- Distance d = (term_val-load_val) mod 2^WIDTH when counting up, or (load_val-term_val) mod 2^WIDTH when counting down.
- With no pause, done is high during the cycle after edge E(d+1). In one-shot mode busy falls on the same edge.
- load_val==term_val: done follows edge E1.
- Each paused cycle delays done by exactly one cycle. The pause takes effect on the edge where it is sampled.
- Auto-reload: done pulses every d+1 cycles and busy stays high.
- rst or stop mid-run takes effect on the next edge. No done pulse is issued for an aborted run.

## Structure
- The shared package holds the state encoding (2-bit localparams IDLE=0, RUN=1, PAUSED=2, DONE=3) and the dir encoding constants.
- Sub-module counter_core: a WIDTH-bit synchronous register with load, en and dir inputs and a count output. It contains no control logic.
- counter_seq_ctrl contains the FSM, the config latches, the terminal comparator and the done register, and instantiates counter_core.

## Test plan
- Reset, then start with load=2, term=5, dir=0, one-shot -> count 2,3,4,5; done high exactly one cycle after the 5th edge; state DONE; count holds 5; busy=0.
- Wrap: load=6, term=1, dir=0 -> count 6,7,0,1; done after the 5th edge. Down-count load=1, term=6 -> count 1,0,7,6.
- Pause: same run as the first scenario, with pause high for 3 cycles while count=3 -> count holds 3; done delayed by exactly 3 cycles; no done pulse while PAUSED.
- Auto-reload: load=0, term=2 -> count 0,1,2,0,1,2,...; done pulses every 3 cycles; busy stays 1; start pulses mid-run are ignored.
- Abort and reset: stop at count=4 -> IDLE, count=4, no done. Then rst asserted during RUN -> count=0, busy=0, done=0 the next cycle.
- load_val==term_val=3 -> done after the 2nd edge; a start in the DONE state relaunches the run.
